// File: rtl/dac_pkg.sv
// Shared types and helpers for the sigma-delta DAC sample path.
package dac_pkg;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_PRIME,
        FEED_PLAY
    } feed_state_t;

    // Offset-binary zero: only the MSB of a width-bit sample is set.
    function automatic logic [31:0] midscale(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // NOTE: storage is deliberately not reset; level_q decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers producer samples, primes the FIFO, then paces them to the DAC at a programmable rate;
// holds the last sample on underrun and parks the output at midscale when stopped.
module dac_sample_feeder
    import dac_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DIV_WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [DIV_WIDTH-1:0]       div,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [WIDTH-1:0]           dac_data,
    output logic                       dac_ena,
    output logic                       sample_tick,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underrun,
    input  logic                       clr_underrun
);

    localparam int                LW       = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0]  MIDSCALE = WIDTH'(midscale(WIDTH));
    localparam logic [LW-1:0]     PRIME_LV = LW'(DEPTH / 2);

    feed_state_t          state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0]     dac_data_q;
    logic                 dac_ena_q;
    logic                 sample_tick_q;
    logic                 underrun_q;

    logic [WIDTH-1:0]     fifo_head;
    logic [LW-1:0]        fifo_level;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 tick;
    logic                 play_tick;
    logic                 pop;
    logic                 starve;

    assign wr_ready = !fifo_full;
    assign push     = wr_valid && wr_ready;

    // Compare with >= so a div lowered mid-period fires immediately instead of wrapping.
    assign tick      = (state_q == FEED_PLAY) && (cnt_q >= div);
    assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
    assign play_tick = tick && run;
    assign pop       = play_tick && !fifo_empty;
    assign starve    = play_tick && fifo_empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (wr_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FEED_IDLE;
            cnt_q         <= '0;
            dac_data_q    <= MIDSCALE;
            dac_ena_q     <= 1'b0;
            sample_tick_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            sample_tick_q <= pop;

            // A starve event in the same cycle as a clear must not be lost.
            if (starve) begin
                underrun_q <= 1'b1;
            end else if (clr_underrun) begin
                underrun_q <= 1'b0;
            end

            case (state_q)
                FEED_IDLE: begin
                    cnt_q      <= '0;
                    dac_data_q <= MIDSCALE;
                    dac_ena_q  <= run;
                    if (run) begin
                        state_q <= FEED_PRIME;
                    end
                end
                FEED_PRIME: begin
                    cnt_q      <= '0;
                    dac_data_q <= MIDSCALE;
                    if (!run) begin
                        state_q   <= FEED_IDLE;
                        dac_ena_q <= 1'b0;
                    end else if (fifo_level >= PRIME_LV) begin
                        state_q <= FEED_PLAY;
                    end
                end
                FEED_PLAY: begin
                    if (!run) begin
                        state_q    <= FEED_IDLE;
                        cnt_q      <= '0;
                        dac_data_q <= MIDSCALE;
                        dac_ena_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (pop) begin
                            dac_data_q <= fifo_head;
                        end
                    end
                end
                default: begin
                    state_q    <= FEED_IDLE;
                    cnt_q      <= '0;
                    dac_data_q <= MIDSCALE;
                    dac_ena_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dac_data    = dac_data_q;
    assign dac_ena     = dac_ena_q;
    assign sample_tick = sample_tick_q;
    assign level       = fifo_level;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed bench for dac_sample_feeder: a vector table for idle buffering plus hand-timed
// sequences for priming, pacing, underrun, stop-on-tick, full FIFO and mid-stream reset.
module tb_dac_sample_feeder;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int DIV_WIDTH = 18;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 run;
    logic [DIV_WIDTH-1:0] div;
    logic [WIDTH-1:0]     wr_data;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [WIDTH-1:0]     dac_data;
    logic                 dac_ena;
    logic                 sample_tick;
    logic [LW-1:0]        level;
    logic                 underrun;
    logic                 clr_underrun;

    int errors = 0;
    int checks = 0;

    dac_sample_feeder #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .div          (div),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .dac_data     (dac_data),
        .dac_ena      (dac_ena),
        .sample_tick  (sample_tick),
        .level        (level),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       wr_valid;
        logic [7:0] wr_data;
        int         exp_level;
        logic       exp_ready;
        logic [7:0] exp_data;
        logic       exp_ena;
        logic       exp_tick;
    } vec_t;

    vec_t t1 [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".level"},    32'(level),       32'd0);
        check({tag, ".wr_ready"}, 32'(wr_ready),    32'd1);
        check({tag, ".dac_data"}, 32'(dac_data),    32'h80);
        check({tag, ".dac_ena"},  32'(dac_ena),     32'd0);
        check({tag, ".tick"},     32'(sample_tick), 32'd0);
        check({tag, ".underrun"}, 32'(underrun),    32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        run          = 1'b0;
        div          = '0;
        wr_data      = '0;
        wr_valid     = 1'b0;
        clr_underrun = 1'b0;

        // ---------------- 1: buffering while stopped ----------------
        t1[0] = '{run: 1'b0, wr_valid: 1'b1, wr_data: 8'h55, exp_level: 1, exp_ready: 1'b1,
                  exp_data: 8'h80, exp_ena: 1'b0, exp_tick: 1'b0};
        t1[1] = '{run: 1'b0, wr_valid: 1'b1, wr_data: 8'h56, exp_level: 2, exp_ready: 1'b1,
                  exp_data: 8'h80, exp_ena: 1'b0, exp_tick: 1'b0};
        t1[2] = '{run: 1'b0, wr_valid: 1'b1, wr_data: 8'h57, exp_level: 3, exp_ready: 1'b1,
                  exp_data: 8'h80, exp_ena: 1'b0, exp_tick: 1'b0};
        t1[3] = '{run: 1'b0, wr_valid: 1'b0, wr_data: 8'h00, exp_level: 3, exp_ready: 1'b1,
                  exp_data: 8'h80, exp_ena: 1'b0, exp_tick: 1'b0};

        do_reset();
        check_reset_state("reset");

        for (int i = 0; i < 4; i++) begin
            run      = t1[i].run;
            wr_valid = t1[i].wr_valid;
            wr_data  = t1[i].wr_data;
            step();
            check($sformatf("t1[%0d].level", i),    32'(level),       32'(t1[i].exp_level));
            check($sformatf("t1[%0d].wr_ready", i), 32'(wr_ready),    32'(t1[i].exp_ready));
            check($sformatf("t1[%0d].dac_data", i), 32'(dac_data),    32'(t1[i].exp_data));
            check($sformatf("t1[%0d].dac_ena", i),  32'(dac_ena),     32'(t1[i].exp_ena));
            check($sformatf("t1[%0d].tick", i),     32'(sample_tick), 32'(t1[i].exp_tick));
        end

        do_reset();
        check("t1.reset_discards", 32'(level), 32'd0);

        // ---------------- 2: prime then paced playback, div=3 ----------------
        div = 18'd3;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h10 + 8'(i);
            step();
            check($sformatf("t2.prime_level[%0d]", i), 32'(level),    32'(i + 1));
            check($sformatf("t2.prime_ena[%0d]", i),   32'(dac_ena),  32'd1);
            check($sformatf("t2.prime_data[%0d]", i),  32'(dac_data), 32'h80);
        end
        wr_valid = 1'b0;
        step();  // PRIME -> PLAY on this edge
        check("t2.play_entry_data", 32'(dac_data),    32'h80);
        check("t2.play_entry_tick", 32'(sample_tick), 32'd0);
        check("t2.play_entry_lvl",  32'(level),       32'd8);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                check($sformatf("t2.gap_tick[%0d.%0d]", k, j), 32'(sample_tick), 32'd0);
            end
            step();
            check($sformatf("t2.tick[%0d]", k),  32'(sample_tick), 32'd1);
            check($sformatf("t2.data[%0d]", k),  32'(dac_data),    32'(8'h10 + 8'(k)));
            check($sformatf("t2.level[%0d]", k), 32'(level),       32'(7 - k));
        end
        check("t2.no_underrun", 32'(underrun), 32'd0);

        // ---------------- 3: starvation and sticky underrun ----------------
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                wr_valid = (k == 0) && (j < 2);
                wr_data  = 8'hA0 + 8'(j);
                step();
                check($sformatf("t3.gap_tick[%0d.%0d]", k, j), 32'(sample_tick), 32'd0);
            end
            wr_valid = 1'b0;
            step();
            check($sformatf("t3.tick[%0d]", k), 32'(sample_tick), 32'd1);
            check($sformatf("t3.data[%0d]", k), 32'(dac_data),    32'(8'hA0 + 8'(k)));
        end
        check("t3.pre_underrun", 32'(underrun), 32'd0);
        for (int j = 0; j < 3; j++) begin
            step();
        end
        step();  // tick with empty FIFO
        check("t3.underrun_set", 32'(underrun),    32'd1);
        check("t3.hold_data",    32'(dac_data),    32'hA1);
        check("t3.starve_tick",  32'(sample_tick), 32'd0);
        check("t3.starve_ena",   32'(dac_ena),     32'd1);
        step();
        check("t3.sticky", 32'(underrun), 32'd1);
        clr_underrun = 1'b1;
        step();
        check("t3.cleared", 32'(underrun), 32'd0);
        clr_underrun = 1'b0;
        step();
        check("t3.stays_clear", 32'(underrun), 32'd0);
        clr_underrun = 1'b1;
        step();  // tick on empty FIFO together with clear
        check("t3.set_beats_clr", 32'(underrun), 32'd1);
        clr_underrun = 1'b0;

        // ---------------- 5: run falls on a tick cycle ----------------
        wr_valid = 1'b1;
        wr_data  = 8'hB0;
        step();
        wr_data  = 8'hB1;
        step();
        wr_valid = 1'b0;
        check("t5.level_before", 32'(level), 32'd2);
        step();
        check("t5.data_before", 32'(dac_data), 32'hA1);
        run = 1'b0;
        step();  // this cycle would have ticked
        check("t5.data_mid",  32'(dac_data),    32'h80);
        check("t5.ena_off",   32'(dac_ena),     32'd0);
        check("t5.no_tick",   32'(sample_tick), 32'd0);
        check("t5.level",     32'(level),       32'd2);
        check("t5.underrun",  32'(underrun),    32'd1);

        // ---------------- 4 & 6: full FIFO, div=0 streaming, mid-stream reset ----------------
        do_reset();
        check_reset_state("reset2");
        div = '0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h40 + 8'(i);
            step();
            check($sformatf("t4.fill_level[%0d]", i), 32'(level), 32'(i + 1));
        end
        check("t4.full_not_ready", 32'(wr_ready), 32'd0);
        wr_data = 8'h99;
        step();
        check("t4.overflow_ignored", 32'(level),    32'd16);
        check("t4.still_not_ready",  32'(wr_ready), 32'd0);
        wr_valid = 1'b0;
        run      = 1'b1;
        step();
        check("t6.prime_ena",  32'(dac_ena),  32'd1);
        check("t6.prime_data", 32'(dac_data), 32'h80);
        step();
        check("t6.entry_tick", 32'(sample_tick), 32'd0);
        for (int k = 0; k < 11; k++) begin
            step();
            check($sformatf("t6.tick[%0d]", k),  32'(sample_tick), 32'd1);
            check($sformatf("t6.data[%0d]", k),  32'(dac_data),    32'(8'h40 + 8'(k)));
            check($sformatf("t6.level[%0d]", k), 32'(level),       32'(15 - k));
            check($sformatf("t6.ready[%0d]", k), 32'(wr_ready),    32'd1);
        end
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        step();  // push and pop in the same cycle
        check("t4.pushpop_level", 32'(level),       32'd5);
        check("t4.pushpop_data",  32'(dac_data),    32'h4B);
        check("t4.pushpop_tick",  32'(sample_tick), 32'd1);
        wr_valid = 1'b0;
        step();
        check("t6.next_data",  32'(dac_data), 32'h4C);
        check("t6.next_level", 32'(level),    32'd4);
        reset = 1'b1;
        step();
        check_reset_state("t6.midreset");
        reset = 1'b0;
        run   = 1'b0;
        step();
        check_reset_state("t6.after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
